nco_sweep_ctrl: RTL

//  Sequencer that drives the 32-bit freq (phase-increment) input of the NCO. On a start

---
 rtl/nco_pkg.sv | 18 +
 rtl/sweep_dwell_timer.sv | 36 +++
 rtl/nco_sweep_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/nco_pkg.sv
// Shared types and width defaults for the NCO frequency sweep controller.
// Optional triangle (up/down) sweep: build with NCO_SWEEP_TRI_EN defined.
package nco_pkg;

  localparam int FREQ_W  = 32;
  localparam int DWELL_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    DWELL,
    STEP,
    DOWN,
    FINISH
  } sweep_state_t;

  typedef logic [FREQ_W-1:0] freq_t;

endpackage

// File: rtl/sweep_dwell_timer.sv
// Dwell countdown: load wins over tick, counter parks at zero.
// zero flags the last cycle of the current frequency hold.
module sweep_dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] value,
  input  logic               tick,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Linear frequency sweep sequencer feeding the NCO phase increment.
// Define NCO_SWEEP_TRI_EN to sweep back down to f_start before done.
module nco_sweep_ctrl #(
  parameter int FREQ_W  = nco_pkg::FREQ_W,
  parameter int DWELL_W = nco_pkg::DWELL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [FREQ_W-1:0]  f_start,
  input  logic [FREQ_W-1:0]  f_stop,
  input  logic [FREQ_W-1:0]  f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [FREQ_W-1:0]  freq,
  output logic               busy,
  output logic               done
);

  import nco_pkg::*;

  sweep_state_t state_q, state_d;

  logic [FREQ_W-1:0]  freq_q, freq_d;
  logic [FREQ_W-1:0]  f_start_q, f_start_d;
  logic [FREQ_W-1:0]  f_stop_q, f_stop_d;
  logic [FREQ_W-1:0]  f_step_q, f_step_d;
  logic [DWELL_W-1:0] rl_q, rl_d;
  logic               degen_q, degen_d;

  logic               tm_load;
  logic [DWELL_W-1:0] tm_val;
  logic               tm_tick;
  logic               tm_zero;

  logic [FREQ_W:0]    up_sum;
  logic [FREQ_W-1:0]  up_freq;
  logic [FREQ_W-1:0]  target;

  // Carry out of the widened add means we passed the top of the range.
  assign up_sum  = {1'b0, freq_q} + {1'b0, f_step_q};
  assign up_freq = (up_sum[FREQ_W] || (up_sum[FREQ_W-1:0] >= f_stop_q))
                 ? f_stop_q : up_sum[FREQ_W-1:0];
  assign target  = degen_q ? f_start_q : f_stop_q;

`ifdef NCO_SWEEP_TRI_EN
  logic [FREQ_W:0]    dn_diff;
  logic [FREQ_W-1:0]  dn_freq;

  assign dn_diff = {1'b0, freq_q} - {1'b0, f_step_q};
  assign dn_freq = (dn_diff[FREQ_W] || (dn_diff[FREQ_W-1:0] <= f_start_q))
                 ? f_start_q : dn_diff[FREQ_W-1:0];
`endif

  always_comb begin
    state_d   = state_q;
    freq_d    = freq_q;
    f_start_d = f_start_q;
    f_stop_d  = f_stop_q;
    f_step_d  = f_step_q;
    rl_d      = rl_q;
    degen_d   = degen_q;
    tm_load   = 1'b0;
    tm_val    = rl_q;
    tm_tick   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          f_start_d = f_start;
          f_stop_d  = f_stop;
          f_step_d  = f_step;
          rl_d      = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
          degen_d   = (f_step == '0) || (f_start >= f_stop);
          freq_d    = f_start;
          tm_load   = 1'b1;
          tm_val    = rl_d;
          state_d   = DWELL;
        end
      end
      DWELL: begin
        tm_tick = 1'b1;
        if (tm_zero) begin
          if (freq_q == target) begin
`ifdef NCO_SWEEP_TRI_EN
            if (degen_q) begin
              state_d = FINISH;
            end else begin
              freq_d  = dn_freq;
              tm_load = 1'b1;
              state_d = DOWN;
            end
`else
            state_d = FINISH;
`endif
          end else begin
            freq_d  = up_freq;
            tm_load = 1'b1;
          end
        end
      end
`ifdef NCO_SWEEP_TRI_EN
      DOWN: begin
        tm_tick = 1'b1;
        if (tm_zero) begin
          if (freq_q == f_start_q) begin
            state_d = FINISH;
          end else begin
            freq_d  = dn_freq;
            tm_load = 1'b1;
          end
        end
      end
`endif
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      freq_d  = '0;
      tm_load = 1'b1;
      tm_val  = '0;
      tm_tick = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      freq_q    <= '0;
      f_start_q <= '0;
      f_stop_q  <= '0;
      f_step_q  <= '0;
      rl_q      <= '0;
      degen_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      freq_q    <= freq_d;
      f_start_q <= f_start_d;
      f_stop_q  <= f_stop_d;
      f_step_q  <= f_step_d;
      rl_q      <= rl_d;
      degen_q   <= degen_d;
    end
  end

  sweep_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tm_load),
    .value (tm_val),
    .tick  (tm_tick),
    .zero  (tm_zero)
  );

  assign freq = freq_q;
  assign busy = (state_q == DWELL) || (state_q == STEP) || (state_q == DOWN);
  assign done = (state_q == FINISH);

endmodule
